// File: rtl/cdc_hs_arb.sv
// -----------------------------------------------------------------------------
// cdc_hs_arb
//
// Round-robin arbiter that shares one 4-phase request/acknowledge channel
// between NREQ local requesters. The winner's payload and index are captured
// into output registers, xfer_req is raised toward the far clock domain, and
// the channel is released again once the far side has acknowledged (or the
// acknowledge did not arrive within TIMEOUT cycles) and has dropped its
// acknowledge. Completion is reported with a one-cycle done or err pulse on
// the bit of the requester that owned the transfer.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   WIDTH    payload width per requester
//   TIMEOUT  cycles to wait for the acknowledge before aborting (1..65535)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request level, held until done/err
//   data       payloads, requester i at [i*WIDTH +: WIDTH]
//   done       one-cycle pulse: transfer of requester i completed
//   err        one-cycle pulse: transfer of requester i timed out
//   xfer_req   4-phase request toward the far domain
//   xfer_data  registered payload of the granted requester
//   xfer_id    index of the granted requester
//   xfer_ack   asynchronous 4-phase acknowledge from the far domain
//   busy       high whenever the channel is not idle
// -----------------------------------------------------------------------------
module cdc_hs_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic                      xfer_req,
    output logic [WIDTH-1:0]          xfer_data,
    output logic [$clog2(NREQ)-1:0]   xfer_id,
    input  logic                      xfer_ack,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = 16;

    // Last counter value at which the acknowledge is still accepted.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ACKLO = 2'd2;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             abort_q,     abort_d;
    logic             xfer_req_q,  xfer_req_d;
    logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic [IDW-1:0]   xfer_id_q,   xfer_id_d;
    logic [NREQ-1:0]  done_q,      done_d;
    logic [NREQ-1:0]  err_q,       err_d;
    logic             busy_q,      busy_d;

    // Two-flop synchronizer for the asynchronous acknowledge. Only the
    // second stage (ack_s_q) is ever looked at by the control logic.
    logic             ack_meta_q;
    logic             ack_s_q;

    // -------------------------------------------------------------------------
    // Payload unpacking and rotated search order
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] data_arr [NREQ];
    logic [IDW-1:0]   rot_idx  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        logic [IDW:0] sum;

        assign data_arr[gi] = data[gi*WIDTH +: WIDTH];

        // rot_idx[k] = (ptr + k) mod NREQ; both operands are below NREQ so
        // one conditional subtraction is enough for the wrap.
        assign sum         = {1'b0, ptr_q} + (IDW+1)'(gi);
        assign rot_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                     : IDW'(sum);
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first set request at or after ptr, with wrap.
    // Scanning from the far end lets the nearest candidate overwrite.
    // -------------------------------------------------------------------------
    logic           rr_found;
    logic [IDW-1:0] rr_winner;

    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rot_idx[k]]) begin
                rr_found  = 1'b1;
                rr_winner = rot_idx[k];
            end
        end
    end

    // A completion pulse is on the outputs this cycle. The owning requester
    // may still show its request level, so no grant is made now.
    logic pulse_active;
    assign pulse_active = (|done_q) | (|err_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic finish;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        xfer_id_d   = xfer_id_q;
        finish      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rr_found && !pulse_active) begin
                    xfer_data_d = data_arr[rr_winner];
                    xfer_id_d   = rr_winner;
                    xfer_req_d  = 1'b1;
                    cnt_d       = '0;
                    abort_d     = 1'b0;
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // The acknowledge is checked first so that an acknowledge
                // arriving on the last allowed cycle is a success.
                if (ack_s_q) begin
                    xfer_req_d = 1'b0;
                    state_d    = S_ACKLO;
                end else if (cnt_q == TO_LAST) begin
                    xfer_req_d = 1'b0;
                    abort_d    = 1'b1;
                    state_d    = S_ACKLO;
                end
            end

            S_ACKLO: begin
                // No timeout here: the far side must return to idle before
                // the channel can be used again.
                if (!ack_s_q) begin
                    finish  = 1'b1;
                    ptr_d   = (xfer_id_q == IDW'(NREQ - 1)) ? '0 : xfer_id_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end

            default: begin
                xfer_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        done_d = '0;
        err_d  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (finish && (xfer_id_q == IDW'(i))) begin
                done_d[i] = ~abort_q;
                err_d[i]  = abort_q;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            xfer_id_q   <= '0;
            done_q      <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            xfer_id_q   <= xfer_id_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ack_meta_q  <= xfer_ack;
            ack_s_q     <= ack_meta_q;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign xfer_id   = xfer_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cdc_hs_arb.sv
// -----------------------------------------------------------------------------
// tb_cdc_hs_arb
//
// Self-checking bench for cdc_hs_arb (NREQ=4, WIDTH=8, TIMEOUT=10). The bench
// plays the far side of the handshake and the requesters. Expected grants come
// from a round-robin pick over the request vector; expected outcome, request
// length and completion cycle come from the handshake rules: the acknowledge
// reaches the arbiter two cycles after it is driven, and the completion pulse
// is registered one cycle after the arbiter sees the acknowledge low.
// -----------------------------------------------------------------------------
module tb_cdc_hs_arb;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 10;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b1;
    logic [NREQ-1:0]       req      = '0;
    logic [NREQ*WIDTH-1:0] data     = '0;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic                  xfer_req;
    logic [WIDTH-1:0]      xfer_data;
    logic [1:0]            xfer_id;
    logic                  xfer_ack = 1'b0;
    logic                  busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int model_ptr = 0;

    cdc_hs_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .done      (done),
        .err       (err),
        .xfer_req  (xfer_req),
        .xfer_data (xfer_data),
        .xfer_id   (xfer_id),
        .xfer_ack  (xfer_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] lane(input logic [NREQ*WIDTH-1:0] d, input int i);
        return d[i*WIDTH +: WIDTH];
    endfunction

    // acknowledge driven at cycle a is seen by the arbiter at cycle a+2,
    // which must be no later than the last allowed cycle TIMEOUT-1
    function automatic bit exp_ok(input int ack_at);
        return (ack_at >= 0) && (ack_at + 2 <= TIMEOUT - 1);
    endfunction

    function automatic int exp_len(input int ack_at);
        return exp_ok(ack_at) ? ack_at + 3 : TIMEOUT;
    endfunction

    function automatic int exp_end(input int ack_at, input int rel_after, input int rel_min);
        int len;
        int rel;
        len = exp_len(ack_at);
        if (ack_at < 0) return len + 1;
        rel = len + rel_after;
        if (rel_min > rel) rel = rel_min;
        return rel + 3;
    endfunction

    // ---------------- far-side agent ----------------
    // Waits for xfer_req, then runs the handshake: raises xfer_ack ack_at
    // cycles after xfer_req was first seen (never if negative), drops it
    // rel_after cycles after xfer_req falls but not before cycle rel_min.
    // Returns at the negedge where a done/err pulse is first seen.
    task automatic drive_xfer(input int ack_at, input int rel_after, input int rel_min,
                              input bit scramble,
                              output int o_wait, output int o_pre, output int o_id,
                              output logic [WIDTH-1:0] o_data, output int o_len,
                              output int o_end, output logic [NREQ-1:0] o_done,
                              output logic [NREQ-1:0] o_err, output int o_unstable,
                              output int o_busy_bad, output logic o_busy_end);
        int low_seen;
        o_wait = 0; o_pre = 0; o_id = -1; o_data = '0; o_len = 0; o_end = -1;
        o_done = '0; o_err = '0; o_unstable = 0; o_busy_bad = 0; o_busy_end = 1'b1;
        while (xfer_req !== 1'b1 && o_wait < 20) begin
            @(negedge clk);
            o_wait++;
            if ((done | err) !== '0) o_pre++;
        end
        if (xfer_req !== 1'b1) return;
        o_id     = int'(xfer_id);
        o_data   = xfer_data;
        low_seen = -1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            if ((done | err) !== '0) begin
                o_done     = done;
                o_err      = err;
                o_end      = c;
                o_busy_end = busy;
                break;
            end
            if (busy !== 1'b1) o_busy_bad++;
            if (xfer_req === 1'b1) begin
                if (low_seen >= 0) o_unstable++;
                o_len++;
                if (xfer_id !== 2'(o_id) || xfer_data !== o_data) o_unstable++;
            end else if (low_seen < 0) begin
                low_seen = c;
            end
            if (scramble && c == 1) begin
                req  = '0;
                data = $urandom;
            end
            if (ack_at >= 0 && c == ack_at) xfer_ack = 1'b1;
            if (low_seen >= 0 && c >= low_seen + rel_after && c >= rel_min) xfer_ack = 1'b0;
        end
        xfer_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        data = $urandom;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, err, xfer_req, xfer_data, xfer_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b err=%b xfer_req=%b data=%h id=%0d busy=%b required all zero",
                     done, err, xfer_req, xfer_data, xfer_id, busy);
        end
        rst = 1'b0;
        req = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({xfer_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got xfer_req=%b busy=%b required 0 0", xfer_req, busy);
        end
        $display("reset: outputs cleared, idle with no request");
    endtask

    task automatic test_back_to_back();
        int w, pre, id, len, endc, unst, bb, exp_id;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        req  = '1;
        for (int t = 0; t < 5; t++) begin
            exp_id = rr_pick(req, model_ptr);
            drive_xfer(1, 1, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
            $display("b2b #%0d: id=%0d data=%02h len=%0d wait=%0d done=%b err=%b", t, id, d, len, w, dn, er);
            n_checks++;
            if (id !== exp_id) begin n_fail++; $display("FAIL b2b_id: got %0d required %0d", id, exp_id); end
            n_checks++;
            if (d !== lane(data, exp_id)) begin n_fail++; $display("FAIL b2b_data: got %h required %h", d, lane(data, exp_id)); end
            n_checks++;
            if (dn !== NREQ'(1 << exp_id) || er !== '0) begin
                n_fail++; $display("FAIL b2b_pulse: got done=%b err=%b required done=%b err=0", dn, er, NREQ'(1 << exp_id));
            end
            n_checks++;
            if (w !== ((t == 0) ? 1 : 2)) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles required %0d", w, (t == 0) ? 1 : 2); end
            n_checks++;
            if (endc !== exp_end(1, 1, 0) || len !== exp_len(1)) begin
                n_fail++; $display("FAIL b2b_timing: got len=%0d end=%0d required len=%0d end=%0d", len, endc, exp_len(1), exp_end(1, 1, 0));
            end
            n_checks++;
            if (pre !== 0 || unst !== 0 || bb !== 0) begin
                n_fail++; $display("FAIL b2b_hold: got pre=%0d unstable=%0d busy_bad=%0d required 0", pre, unst, bb);
            end
            model_ptr = (exp_id + 1) % NREQ;
        end
        req = '0;
    endtask

    task automatic test_single();
        int w, pre, id, len, endc, unst, bb;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        data[23:16] = 8'hA5;
        req = 4'b0100;
        drive_xfer(3, 3, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        req = '0;
        $display("single: id=%0d data=%02h len=%0d end=%0d done=%b err=%b busy=%b", id, d, len, endc, dn, er, be);
        n_checks++;
        if (id !== 2 || d !== 8'hA5) begin n_fail++; $display("FAIL single_grant: got id=%0d data=%h required id=2 data=a5", id, d); end
        n_checks++;
        if (dn !== 4'b0100 || er !== 4'b0000) begin n_fail++; $display("FAIL single_pulse: got done=%b err=%b required 0100 0000", dn, er); end
        n_checks++;
        if (w !== 1) begin n_fail++; $display("FAIL single_latency: got %0d required 1", w); end
        n_checks++;
        if (len !== exp_len(3) || endc !== exp_end(3, 3, 0)) begin
            n_fail++; $display("FAIL single_timing: got len=%0d end=%0d required len=%0d end=%0d", len, endc, exp_len(3), exp_end(3, 3, 0));
        end
        n_checks++;
        if (be !== 1'b0 || bb !== 0) begin n_fail++; $display("FAIL single_busy: got end=%b bad=%0d required 0 0", be, bb); end
        model_ptr = 3;
    endtask

    task automatic test_timeout();
        int w, pre, id, len, endc, unst, bb;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        req = 4'b0010;
        drive_xfer(-1, 0, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        req = '0;
        $display("timeout: id=%0d len=%0d end=%0d done=%b err=%b", id, len, endc, dn, er);
        n_checks++;
        if (id !== 1 || d !== lane(data, 1)) begin n_fail++; $display("FAIL timeout_grant: got id=%0d data=%h required 1 %h", id, d, lane(data, 1)); end
        n_checks++;
        if (len !== TIMEOUT) begin n_fail++; $display("FAIL timeout_len: got %0d required %0d", len, TIMEOUT); end
        n_checks++;
        if (er !== 4'b0010 || dn !== 4'b0000) begin n_fail++; $display("FAIL timeout_pulse: got done=%b err=%b required 0000 0010", dn, er); end
        n_checks++;
        if (endc !== exp_end(-1, 0, 0)) begin n_fail++; $display("FAIL timeout_end: got %0d required %0d", endc, exp_end(-1, 0, 0)); end
        model_ptr = 2;
    endtask

    task automatic test_ack_held();
        int w, pre, id, len, endc, unst, bb;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        req = 4'b0001;
        drive_xfer(3, 0, 40, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        req = '0;
        $display("ack_held: id=%0d len=%0d end=%0d done=%b err=%b", id, len, endc, dn, er);
        n_checks++;
        if (len !== exp_len(3)) begin n_fail++; $display("FAIL held_len: got %0d required %0d", len, exp_len(3)); end
        n_checks++;
        if (endc !== exp_end(3, 0, 40)) begin n_fail++; $display("FAIL held_end: got %0d required %0d", endc, exp_end(3, 0, 40)); end
        n_checks++;
        if (dn !== 4'b0001 || er !== 4'b0000) begin n_fail++; $display("FAIL held_pulse: got done=%b err=%b required 0001 0000", dn, er); end
        model_ptr = 1;
    endtask

    task automatic test_ack_at_timeout();
        int w, pre, id, len, endc, unst, bb, exp_id;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er, edn, eer;
        logic be;
        for (int a = TIMEOUT - 3; a <= TIMEOUT - 2; a++) begin
            repeat (2) @(negedge clk);
            data = $urandom;
            req  = NREQ'(1 << $urandom_range(0, NREQ - 1));
            exp_id = rr_pick(req, model_ptr);
            drive_xfer(a, 0, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
            req = '0;
            edn = exp_ok(a) ? NREQ'(1 << exp_id) : '0;
            eer = exp_ok(a) ? '0 : NREQ'(1 << exp_id);
            $display("ack_edge a=%0d: id=%0d len=%0d end=%0d done=%b err=%b", a, id, len, endc, dn, er);
            n_checks++;
            if (dn !== edn || er !== eer) begin n_fail++; $display("FAIL edge_pulse: got done=%b err=%b required %b %b", dn, er, edn, eer); end
            n_checks++;
            if (len !== exp_len(a) || endc !== exp_end(a, 0, 0)) begin
                n_fail++; $display("FAIL edge_timing: got len=%0d end=%0d required %0d %0d", len, endc, exp_len(a), exp_end(a, 0, 0));
            end
            model_ptr = (exp_id + 1) % NREQ;
        end
    endtask

    task automatic test_req_drop();
        int w, pre, id, len, endc, unst, bb, exp_id;
        logic [WIDTH-1:0] d, exp_d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        req  = 4'b1010;
        exp_id = rr_pick(req, model_ptr);
        exp_d  = lane(data, exp_id);
        drive_xfer(2, 2, 0, 1'b1, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        $display("req_drop: id=%0d data=%02h done=%b err=%b unstable=%0d", id, d, dn, er, unst);
        n_checks++;
        if (id !== exp_id || d !== exp_d) begin n_fail++; $display("FAIL drop_grant: got %0d %h required %0d %h", id, d, exp_id, exp_d); end
        n_checks++;
        if (unst !== 0) begin n_fail++; $display("FAIL drop_hold: got %0d changes required 0", unst); end
        n_checks++;
        if (dn !== NREQ'(1 << exp_id) || er !== '0) begin n_fail++; $display("FAIL drop_pulse: got done=%b err=%b required %b 0000", dn, er, NREQ'(1 << exp_id)); end
        model_ptr = (exp_id + 1) % NREQ;
    endtask

    task automatic test_reset_mid();
        int w, pre, id, len, endc, unst, bb, k;
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0] dn, er;
        logic be;
        repeat (2) @(negedge clk);
        data = $urandom;
        data[23:16] = 8'h5A;
        req = 4'b0100;
        k = 0;
        while (xfer_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: got xfer_req=%b required 1", xfer_req); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({done, err, xfer_req, xfer_data, xfer_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got done=%b err=%b xfer_req=%b data=%h id=%0d busy=%b required all zero",
                     done, err, xfer_req, xfer_data, xfer_id, busy);
        end
        model_ptr = 0;
        rst  = 1'b0;
        data = $urandom;
        req  = 4'b1001;
        drive_xfer(1, 1, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        $display("rst_mid: first grant id=%0d done=%b err=%b", id, dn, er);
        n_checks++;
        if (id !== rr_pick(4'b1001, 0) || pre !== 0) begin n_fail++; $display("FAIL rstmid_ptr: got id=%0d pre=%0d required %0d 0", id, pre, rr_pick(4'b1001, 0)); end
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        req = 4'b1000;
        drive_xfer(1, 1, 0, 1'b0, w, pre, id, d, len, endc, dn, er, unst, bb, be);
        $display("rst_mid: lone grant id=%0d done=%b wait=%0d", id, dn, w);
        n_checks++;
        if (id !== 3 || w !== 1) begin n_fail++; $display("FAIL rstmid_lone: got id=%0d wait=%0d required 3 1", id, w); end
        n_checks++;
        if (dn !== 4'b1000 || er !== 4'b0000) begin n_fail++; $display("FAIL rstmid_pulse: got done=%b err=%b required 1000 0000", dn, er); end
        req = '0;
        model_ptr = 0;
    endtask

    task automatic test_random();
        int w, pre, id, len, endc, unst, bb, exp_id, a, ra;
        bit scr;
        logic [WIDTH-1:0] d, exp_d;
        logic [NREQ-1:0] dn, er, edn, eer;
        logic be;
        for (int t = 0; t < 40; t++) begin
            req  = NREQ'($urandom_range(1, 15));
            data = $urandom;
            a    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 2));
            ra   = int'($urandom_range(0, 4));
            scr  = ($urandom_range(0, 3) == 0);
            exp_id = rr_pick(req, model_ptr);
            exp_d  = lane(data, exp_id);
            edn = exp_ok(a) ? NREQ'(1 << exp_id) : '0;
            eer = exp_ok(a) ? '0 : NREQ'(1 << exp_id);
            drive_xfer(a, ra, 0, scr, w, pre, id, d, len, endc, dn, er, unst, bb, be);
            $display("rand #%0d: req_id=%0d data=%02h ack_at=%0d len=%0d end=%0d done=%b err=%b", t, id, d, a, len, endc, dn, er);
            n_checks++;
            if (id !== exp_id || d !== exp_d) begin n_fail++; $display("FAIL rand_grant: got %0d %h required %0d %h", id, d, exp_id, exp_d); end
            n_checks++;
            if (dn !== edn || er !== eer) begin n_fail++; $display("FAIL rand_pulse: got done=%b err=%b required %b %b", dn, er, edn, eer); end
            n_checks++;
            if (len !== exp_len(a) || endc !== exp_end(a, ra, 0)) begin
                n_fail++; $display("FAIL rand_timing: got len=%0d end=%0d required %0d %0d", len, endc, exp_len(a), exp_end(a, ra, 0));
            end
            n_checks++;
            if (w !== 2 || pre !== 0) begin n_fail++; $display("FAIL rand_gap: got wait=%0d pre=%0d required 2 0", w, pre); end
            n_checks++;
            if (unst !== 0 || bb !== 0 || be !== 1'b0) begin
                n_fail++; $display("FAIL rand_hold: got unstable=%0d busy_bad=%0d busy_end=%b required 0 0 0", unst, bb, be);
            end
            model_ptr = (exp_id + 1) % NREQ;
        end
        req = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_single();
        test_timeout();
        test_ack_held();
        test_ack_at_timeout();
        test_req_drop();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_hs_arb.md
CDC_HS_ARB -- requirements
Module: cdc_hs_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one handshake channel (2..8).
REQ-002 Parameter WIDTH, default 8, payload width per requester.
REQ-003 Parameter TIMEOUT, default 255, cycles to wait for ack assertion before abort (1..65535).
REQ-004 Port clk  input  1  sole clock, all logic rising-edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req  input  NREQ  per-requester level request; held high until done or err for that bit.
REQ-007 Port data  input  NREQ*WIDTH  payload, requester i in bits [i*WIDTH +: WIDTH]; stable while req[i] high.
REQ-008 Port done  output  NREQ  one-cycle pulse, transfer for requester i completed.
REQ-009 Port err  output  NREQ  one-cycle pulse, transfer for requester i aborted by timeout.
REQ-010 Port xfer_req  output  1  4-phase request level toward far domain.
REQ-011 Port xfer_data  output  WIDTH  registered payload, stable while xfer_req high.
REQ-012 Port xfer_id  output  clog2(NREQ)  index of granted requester, stable with xfer_data.
REQ-013 Port xfer_ack  input  1  asynchronous 4-phase acknowledge from far domain.
REQ-014 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 xfer_ack SHALL pass through exactly two internal flops (ack_s); FSM uses only ack_s.
REQ-016 FSM states: IDLE, REQ, ACKLO; no other reachable state.
REQ-017 IDLE: if any req bit high, grant via round-robin, next state REQ; else remain IDLE.
REQ-018 Round-robin: search starts at pointer ptr, ascending with wrap NREQ-1 -> 0; first set bit wins.
REQ-019 On grant (IDLE->REQ edge): xfer_data <= data of winner, xfer_id <= winner, xfer_req <= 1, timeout counter <= 0, abort flag <= 0.
REQ-020 REQ: counter increments each cycle; if ack_s=1, xfer_req <= 0, next ACKLO.
REQ-021 REQ: if ack_s=0 and counter == TIMEOUT-1, xfer_req <= 0, abort flag <= 1, next ACKLO; counter saturates, never wraps.
REQ-022 REQ: simultaneous ack_s=1 and timeout SHALL count as success (abort flag stays 0).
REQ-023 ACKLO: wait for ack_s=0; then pulse done[xfer_id] (abort=0) or err[xfer_id] (abort=1) for one cycle, ptr <= (xfer_id+1) mod NREQ, next IDLE.
REQ-024 ACKLO has no timeout; channel SHALL NOT re-arm until ack_s=0 is observed.
REQ-025 Latency: req[i] high in IDLE -> xfer_req high next cycle; done/err coincides with return to IDLE.
REQ-026 A req bit still high in the cycle after its done/err is a new request; IDLE SHALL NOT grant in the done cycle (minimum one IDLE cycle between transfers).
REQ-027 req bits deasserted while granted SHALL NOT affect the in-flight transfer; xfer_data/xfer_id hold.
REQ-028 At most one done/err bit high per cycle; done and err never high together.
REQ-029 xfer_req, xfer_data, xfer_id, done, err, busy SHALL be register outputs (no combinational path from inputs).

Reset
REQ-030 rst=1 at a clock edge: state IDLE, xfer_req 0, xfer_data 0, xfer_id 0, done 0, err 0, busy 0, ptr 0, counter 0, abort 0, both sync flops 0.
REQ-031 Reset mid-transfer SHALL drop xfer_req the next cycle without done/err pulses; first grant after reset obeys REQ-018 with ptr 0.

Verification
REQ-032 NREQ=4, req=4'b0100, data[2]=8'hA5; far side acks 3 cycles after xfer_req, releases 3 cycles after drop -> xfer_id=2, xfer_data=8'hA5, single done=4'b0100 pulse, busy low after.
REQ-033 req=4'b1111 held, far side auto-acks -> grant order 0,1,2,3,0, one done each, ≥1 IDLE cycle between transfers.
REQ-034 TIMEOUT=10, xfer_ack tied 0, req[1]=1 -> xfer_req high exactly 10 cycles, then err=4'b0010 pulse, no done.
REQ-035 TIMEOUT=10, xfer_ack held 1 from cycle 3 to 40 -> xfer_req drops on ack_s, done pulse only after ack_s falls (~cycle 42), no err.
REQ-036 rst asserted while in REQ with xfer_req=1 -> next cycle all outputs 0; after release, req=4'b1000 with ptr 0 grants id 3.
REQ-037 ack edge coincident with counter == TIMEOUT-1 -> done pulse, no err.
